alu_acc_unit: RTL and testbench

ALU_ACC_UNIT -- requirements
Module: alu_acc_unit

---
 rtl/alu_acc_unit.sv | 103 ++++++++++
 tb/tb_alu_acc_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_acc_unit.sv
// alu_acc_unit
//   Accumulator-style datapath slice: accumulator A, operand register B,
//   result register R and zero/carry flags, attached to a shared 8-bit bus.
//
// Ports
//   clk      in   system clock, all state changes on the rising edge
//   rst      in   synchronous, active-high reset; clears every register
//   bus_in   in   [7:0] value currently on the shared bus
//   a_ld     in   load A from bus_in
//   b_ld     in   load B from bus_in
//   alu_en   in   compute R and flags from the pre-edge A and B
//   alu_op   in   [1:0] 00 ADD, 01 SUB, 10 INC, 11 DEC
//   a_oe     in   drive A onto bus_out
//   r_oe     in   drive R onto bus_out (wins over a_oe)
//   bus_out  out  [7:0] value this block drives toward the bus (0x00 when idle)
//   bus_drv  out  high whenever bus_out carries a valid value
//   flags    out  [1:0] {zero, carry}, straight from registers
//   acc_q    out  [7:0] current A, straight from the register
//   bus_err  out  sticky: a_oe and r_oe were both asserted on some edge
//
// There is no handshake on this block: every control input is a one-cycle
// strobe sampled on the rising edge, and outputs are valid in the same cycle
// (bus_out/bus_drv) or after the edge (everything registered).

module alu_acc_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bus_in,
  input  logic       a_ld,
  input  logic       b_ld,
  input  logic       alu_en,
  input  logic [1:0] alu_op,
  input  logic       a_oe,
  input  logic       r_oe,
  output logic [7:0] bus_out,
  output logic       bus_drv,
  output logic [1:0] flags,
  output logic [7:0] acc_q,
  output logic       bus_err
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_DEC = 2'b11;

  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [7:0] r_q;
  logic       z_q;
  logic       c_q;
  logic       err_q;

  // 9-bit sum; bit 8 is the carry. SUB is A + ~B + 1, so carry set means
  // no borrow (A >= B). DEC is A + 0xFF, so carry set means A was nonzero.
  logic [8:0] sum;

  always_comb begin
    sum = 9'd0;
    case (alu_op)
      OP_ADD:  sum = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:  sum = {1'b0, a_q} + {1'b0, ~b_q} + 9'd1;
      OP_INC:  sum = {1'b0, a_q} + 9'd1;
      OP_DEC:  sum = {1'b0, a_q} + 9'h0FF;
      default: sum = 9'd0;
    endcase
  end

  // The ALU reads the register values present before the edge, so a_ld/b_ld
  // in the same cycle as alu_en only affect the following operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      r_q   <= 8'h00;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (a_ld) a_q <= bus_in;
      if (b_ld) b_q <= bus_in;
      if (alu_en) begin
        r_q <= sum[7:0];
        z_q <= (sum[7:0] == 8'h00);
        c_q <= sum[8];
      end
      if (a_oe && r_oe) err_q <= 1'b1;
    end
  end

  // Bus drive: R has priority over A; 0x00 when nothing is enabled.
  always_comb begin
    bus_out = 8'h00;
    if (r_oe)      bus_out = r_q;
    else if (a_oe) bus_out = a_q;
  end

  assign bus_drv = a_oe | r_oe;
  assign flags   = {z_q, c_q};
  assign acc_q   = a_q;
  assign bus_err = err_q;

endmodule

// File: tb/tb_alu_acc_unit.sv
// tb_alu_acc_unit
//   Directed-vector bench for alu_acc_unit. Each test task drives its own
//   stimulus and compares outputs against hand-computed values. Expected
//   ALU results are queued in exp_q ahead of the operation and popped at
//   the point where R is observed on bus_out.

module tb_alu_acc_unit;

  logic       clk;
  logic       rst;
  logic [7:0] bus_in;
  logic       a_ld;
  logic       b_ld;
  logic       alu_en;
  logic [1:0] alu_op;
  logic       a_oe;
  logic       r_oe;
  logic [7:0] bus_out;
  logic       bus_drv;
  logic [1:0] flags;
  logic [7:0] acc_q;
  logic       bus_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_r;

  alu_acc_unit dut (
    .clk     (clk),
    .rst     (rst),
    .bus_in  (bus_in),
    .a_ld    (a_ld),
    .b_ld    (b_ld),
    .alu_en  (alu_en),
    .alu_op  (alu_op),
    .a_oe    (a_oe),
    .r_oe    (r_oe),
    .bus_out (bus_out),
    .bus_drv (bus_drv),
    .flags   (flags),
    .acc_q   (acc_q),
    .bus_err (bus_err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    rst    = 1'b0;
    bus_in = 8'h00;
    a_ld   = 1'b0;
    b_ld   = 1'b0;
    alu_en = 1'b0;
    alu_op = 2'b00;
    a_oe   = 1'b0;
    r_oe   = 1'b0;
  endtask

  task automatic load_a(input logic [7:0] v);
    bus_in = v;
    a_ld   = 1'b1;
    tick();
    a_ld   = 1'b0;
    bus_in = 8'h00;
  endtask

  task automatic load_b(input logic [7:0] v);
    bus_in = v;
    b_ld   = 1'b1;
    tick();
    b_ld   = 1'b0;
    bus_in = 8'h00;
  endtask

  task automatic run_alu(input logic [1:0] op);
    alu_en = 1'b1;
    alu_op = op;
    tick();
    alu_en = 1'b0;
    alu_op = 2'(($urandom_range(0, 3)));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    idle_inputs();
    rst    = 1'b1;
    bus_in = 8'hA5;
    a_ld   = 1'b1;
    tick();
    tick();
    idle_inputs();
    #1;
    checks++; if (acc_q !== 8'h00) begin errors++; $display("FAIL reset_acc: got %h expected 00", acc_q); end
    checks++; if (flags !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", flags); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus_err); end
    checks++; if (bus_out !== 8'h00) begin errors++; $display("FAIL reset_bus_out: got %h expected 00", bus_out); end
    checks++; if (bus_drv !== 1'b0) begin errors++; $display("FAIL reset_bus_drv: got %b expected 0", bus_drv); end
  endtask

  task automatic test_add;
    load_a(8'h05);
    load_b(8'h03);
    exp_q.push_back(8'h08);
    // cycle n: b_ld + alu_en
    bus_in = 8'h03; b_ld = 1'b1; alu_en = 1'b1; alu_op = 2'b00;
    tick();
    b_ld = 1'b0; alu_en = 1'b0;
    // cycle n+1: r_oe + a_ld, bus looped back into A
    r_oe = 1'b1; a_ld = 1'b1;
    #1;
    exp_r = exp_q.pop_front();
    checks++; if (bus_out !== exp_r) begin errors++; $display("FAIL add_bus_out: got %h expected %h", bus_out, exp_r); end
    checks++; if (bus_drv !== 1'b1) begin errors++; $display("FAIL add_bus_drv: got %b expected 1", bus_drv); end
    bus_in = bus_out;
    tick();
    r_oe = 1'b0; a_ld = 1'b0; bus_in = 8'h00;
    checks++; if (acc_q !== 8'h08) begin errors++; $display("FAIL add_acc: got %h expected 08", acc_q); end
    checks++; if (flags !== 2'b00) begin errors++; $display("FAIL add_flags: got %b expected 00", flags); end
  endtask

  task automatic test_carry_zero;
    load_a(8'hFF);
    load_b(8'h01);
    exp_q.push_back(8'h00);
    run_alu(2'b00);
    r_oe = 1'b1; #1;
    exp_r = exp_q.pop_front();
    checks++; if (bus_out !== exp_r) begin errors++; $display("FAIL add_carry_r: got %h expected %h", bus_out, exp_r); end
    checks++; if (flags !== 2'b11) begin errors++; $display("FAIL add_carry_flags: got %b expected 11", flags); end
    r_oe = 1'b0;
    // clear the flags so the INC result is observably fresh
    load_b(8'h00);
    exp_q.push_back(8'hFF);
    run_alu(2'b00);
    r_oe = 1'b1; #1;
    exp_r = exp_q.pop_front();
    checks++; if (bus_out !== exp_r) begin errors++; $display("FAIL add_ff_r: got %h expected %h", bus_out, exp_r); end
    checks++; if (flags !== 2'b00) begin errors++; $display("FAIL add_ff_flags: got %b expected 00", flags); end
    r_oe = 1'b0;
    exp_q.push_back(8'h00);
    run_alu(2'b10);
    r_oe = 1'b1; #1;
    exp_r = exp_q.pop_front();
    checks++; if (bus_out !== exp_r) begin errors++; $display("FAIL inc_r: got %h expected %h", bus_out, exp_r); end
    checks++; if (flags !== 2'b11) begin errors++; $display("FAIL inc_flags: got %b expected 11", flags); end
    r_oe = 1'b0;
  endtask

  task automatic test_sub;
    load_a(8'h03);
    load_b(8'h05);
    exp_q.push_back(8'hFE);
    run_alu(2'b01);
    r_oe = 1'b1; #1;
    exp_r = exp_q.pop_front();
    checks++; if (bus_out !== exp_r) begin errors++; $display("FAIL sub_borrow_r: got %h expected %h", bus_out, exp_r); end
    checks++; if (flags !== 2'b00) begin errors++; $display("FAIL sub_borrow_flags: got %b expected 00", flags); end
    r_oe = 1'b0;
    load_a(8'h05);
    exp_q.push_back(8'h00);
    run_alu(2'b01);
    r_oe = 1'b1; #1;
    exp_r = exp_q.pop_front();
    checks++; if (bus_out !== exp_r) begin errors++; $display("FAIL sub_equal_r: got %h expected %h", bus_out, exp_r); end
    checks++; if (flags !== 2'b11) begin errors++; $display("FAIL sub_equal_flags: got %b expected 11", flags); end
    r_oe = 1'b0;
  endtask

  task automatic test_dec;
    load_a(8'h00);
    exp_q.push_back(8'hFF);
    run_alu(2'b11);
    r_oe = 1'b1; #1;
    exp_r = exp_q.pop_front();
    checks++; if (bus_out !== exp_r) begin errors++; $display("FAIL dec_zero_r: got %h expected %h", bus_out, exp_r); end
    checks++; if (flags !== 2'b00) begin errors++; $display("FAIL dec_zero_flags: got %b expected 00", flags); end
    r_oe = 1'b0;
    load_a(8'h01);
    exp_q.push_back(8'h00);
    run_alu(2'b11);
    r_oe = 1'b1; #1;
    exp_r = exp_q.pop_front();
    checks++; if (bus_out !== exp_r) begin errors++; $display("FAIL dec_one_r: got %h expected %h", bus_out, exp_r); end
    checks++; if (flags !== 2'b11) begin errors++; $display("FAIL dec_one_flags: got %b expected 11", flags); end
    r_oe = 1'b0;
  endtask

  // R=00, flags=11 on entry; loads, bus activity and alu_op changes without
  // alu_en must leave R and the flags alone.
  task automatic test_hold;
    for (int i = 0; i < 4; i++) begin
      alu_op = 2'(i);
      bus_in = 8'h7E; a_ld = 1'b1; a_oe = 1'b1;
      tick();
    end
    a_ld = 1'b0; a_oe = 1'b0;
    load_b(8'h01);
    checks++; if (flags !== 2'b11) begin errors++; $display("FAIL hold_flags: got %b expected 11", flags); end
    checks++; if (acc_q !== 8'h7E) begin errors++; $display("FAIL hold_acc: got %h expected 7e", acc_q); end
    r_oe = 1'b1; #1;
    checks++; if (bus_out !== 8'h00) begin errors++; $display("FAIL hold_r: got %h expected 00", bus_out); end
    r_oe = 1'b0; a_oe = 1'b1; #1;
    checks++; if (bus_out !== 8'h7E) begin errors++; $display("FAIL a_oe_bus_out: got %h expected 7e", bus_out); end
    a_oe = 1'b0; #1;
    checks++; if (bus_out !== 8'h00) begin errors++; $display("FAIL idle_bus_out: got %h expected 00", bus_out); end
    checks++; if (bus_drv !== 1'b0) begin errors++; $display("FAIL idle_bus_drv: got %b expected 0", bus_drv); end
  endtask

  // A=7E, B=01: load A, compute from old A and show old A, all in one cycle.
  task automatic test_back_to_back;
    exp_q.push_back(8'h7F);
    bus_in = 8'h10; a_ld = 1'b1; alu_en = 1'b1; alu_op = 2'b00; a_oe = 1'b1;
    #1;
    checks++; if (bus_out !== 8'h7E) begin errors++; $display("FAIL same_cycle_old_a: got %h expected 7e", bus_out); end
    tick();
    a_ld = 1'b0; alu_en = 1'b0; a_oe = 1'b0; bus_in = 8'h00;
    checks++; if (acc_q !== 8'h10) begin errors++; $display("FAIL same_cycle_new_a: got %h expected 10", acc_q); end
    r_oe = 1'b1; #1;
    exp_r = exp_q.pop_front();
    checks++; if (bus_out !== exp_r) begin errors++; $display("FAIL same_cycle_r: got %h expected %h", bus_out, exp_r); end
    checks++; if (flags !== 2'b00) begin errors++; $display("FAIL same_cycle_flags: got %b expected 00", flags); end
    r_oe = 1'b0;
  endtask

  // R=7F, A=10 on entry.
  task automatic test_conflict;
    a_oe = 1'b1; r_oe = 1'b1;
    #1;
    checks++; if (bus_out !== 8'h7F) begin errors++; $display("FAIL conflict_bus_out: got %h expected 7f", bus_out); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL conflict_err_early: got %b expected 0", bus_err); end
    tick();
    a_oe = 1'b0; r_oe = 1'b0;
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL conflict_err_set: got %b expected 1", bus_err); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL conflict_err_sticky: got %b expected 1", bus_err); end
    checks++; if (flags !== 2'b00) begin errors++; $display("FAIL conflict_flags: got %b expected 00", flags); end
  endtask

  task automatic test_reset_mid_seq;
    load_a(8'h44);
    load_b(8'h22);
    rst = 1'b1; bus_in = 8'h55; a_ld = 1'b1; b_ld = 1'b1; alu_en = 1'b1;
    alu_op = 2'b00; a_oe = 1'b1; r_oe = 1'b1;
    tick();
    idle_inputs();
    #1;
    checks++; if (acc_q !== 8'h00) begin errors++; $display("FAIL rst_mid_acc: got %h expected 00", acc_q); end
    checks++; if (flags !== 2'b00) begin errors++; $display("FAIL rst_mid_flags: got %b expected 00", flags); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_mid_err: got %b expected 0", bus_err); end
    r_oe = 1'b1; #1;
    checks++; if (bus_out !== 8'h00) begin errors++; $display("FAIL rst_mid_r: got %h expected 00", bus_out); end
    r_oe = 1'b0;
    // B must have been cleared too: 0x21 + B gives 0x21 only if B is zero
    load_a(8'h21);
    exp_q.push_back(8'h21);
    run_alu(2'b00);
    r_oe = 1'b1; #1;
    exp_r = exp_q.pop_front();
    checks++; if (bus_out !== exp_r) begin errors++; $display("FAIL rst_mid_b: got %h expected %h", bus_out, exp_r); end
    r_oe = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_add();
    test_carry_zero();
    test_sub();
    test_dec();
    test_hold();
    test_back_to_back();
    test_conflict();
    test_reset_mid_seq();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL exp_q_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
